// File: rtl/record_play_ctrl.sv
// Record/playback sequencer for the audio sample memory: turns command pulses and the
// sample-rate strobe into registered address / write-enable / read-enable sequences.
module record_play_ctrl #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DEPTH  = 131072
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rec_cmd,
  input  logic              i_play_cmd,
  input  logic              i_stop_cmd,
  input  logic              i_sample_tick,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_mem_we,
  output logic              o_mem_re,
  output logic [ADDR_W:0]   o_rec_len,
  output logic              o_recording,
  output logic              o_playing,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_LEN  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECORD,
    S_PLAY
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic                r_re;
  logic [ADDR_W:0]     r_rec_len;
  logic                r_done;

  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                w_we_nxt;
  logic                w_re_nxt;
  logic [ADDR_W:0]     w_rec_len_nxt;
  logic                w_done_nxt;

  logic [ADDR_W-1:0]   w_addr_inc;
  logic [ADDR_W:0]     w_rec_count;
  logic                w_rec_full;
  logic                w_play_last;
  logic                w_strobe_busy;

  assign w_addr_inc    = r_addr + ADDR_W'(1);
  assign w_strobe_busy = r_we | r_re;
  // A write strobe that is high in the stop cycle still lands, so it is counted.
  assign w_rec_count   = {1'b0, r_addr} + (ADDR_W + 1)'(r_we);
  assign w_rec_full    = r_we && (r_addr == LAST_ADDR);
  assign w_play_last   = r_re && ({1'b0, r_addr} == (r_rec_len - (ADDR_W + 1)'(1)));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_rec_len <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_we      <= w_we_nxt;
      r_re      <= w_re_nxt;
      r_rec_len <= w_rec_len_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_stop_cmd)                            w_state_nxt = S_IDLE;
        else if (i_rec_cmd)                        w_state_nxt = S_RECORD;
        else if (i_play_cmd && (r_rec_len != '0))  w_state_nxt = S_PLAY;
      end
      S_RECORD: begin
        if (i_stop_cmd || w_rec_full)              w_state_nxt = S_IDLE;
      end
      S_PLAY: begin
        if (i_stop_cmd || w_play_last)             w_state_nxt = S_IDLE;
      end
      default:                                     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_addr_nxt    = r_addr;
    w_we_nxt      = 1'b0;
    w_re_nxt      = 1'b0;
    w_rec_len_nxt = r_rec_len;
    w_done_nxt    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!i_stop_cmd && (i_rec_cmd || (i_play_cmd && (r_rec_len != '0))))
          w_addr_nxt = '0;
      end
      S_RECORD: begin
        if (r_we)
          w_addr_nxt = w_addr_inc;
        if (i_sample_tick && !i_stop_cmd && !w_strobe_busy && !w_rec_full)
          w_we_nxt = 1'b1;
        if (i_stop_cmd) begin
          w_rec_len_nxt = w_rec_count;
          w_addr_nxt    = '0;
          w_done_nxt    = 1'b1;
        end else if (w_rec_full) begin
          w_rec_len_nxt = FULL_LEN;
          w_addr_nxt    = '0;
          w_done_nxt    = 1'b1;
        end
      end
      S_PLAY: begin
        if (r_re)
          w_addr_nxt = w_addr_inc;
        if (i_sample_tick && !i_stop_cmd && !w_strobe_busy)
          w_re_nxt = 1'b1;
        if (i_stop_cmd || w_play_last) begin
          w_addr_nxt = '0;
          w_done_nxt = 1'b1;
        end
      end
      default: begin
        w_addr_nxt = '0;
      end
    endcase
  end

  assign o_addr      = r_addr;
  assign o_mem_we    = r_we;
  assign o_mem_re    = r_re;
  assign o_rec_len   = r_rec_len;
  assign o_done      = r_done;
  assign o_recording = (r_state == S_RECORD);
  assign o_playing   = (r_state == S_PLAY);

endmodule

// File: tb/tb_record_play_ctrl.sv
// Scoreboard bench for record_play_ctrl: expected strobes are queued when ticks are driven
// and matched against mem_we/mem_re as they appear.
module tb_record_play_ctrl;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 8;

  logic              clk = 1'b0;
  logic              i_reset, i_rec_cmd, i_play_cmd, i_stop_cmd, i_sample_tick;
  logic [ADDR_W-1:0] o_addr;
  logic              o_mem_we, o_mem_re, o_recording, o_playing, o_done;
  logic [ADDR_W:0]   o_rec_len;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
  } strobe_t;

  strobe_t sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned done_cnt = 0;
  int unsigned exp_done = 0;

  record_play_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_rec_cmd(i_rec_cmd), .i_play_cmd(i_play_cmd),
    .i_stop_cmd(i_stop_cmd), .i_sample_tick(i_sample_tick), .o_addr(o_addr),
    .o_mem_we(o_mem_we), .o_mem_re(o_mem_re), .o_rec_len(o_rec_len),
    .o_recording(o_recording), .o_playing(o_playing), .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    strobe_t e;
    #2;
    if (o_mem_we && o_mem_re) check("we_re_both", 32'(o_mem_we & o_mem_re), 32'd0);
    if (o_mem_we || o_mem_re) begin
      if (sb.size() == 0) begin
        check("unexp_strobe", {30'd0, o_mem_we, o_mem_re}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", {31'd0, o_mem_we}, {31'd0, e.we});
        check("strobe_addr", 32'(o_addr), 32'(e.addr));
      end
    end
    if (o_done) done_cnt++;
  end

  task automatic step(input logic rec, input logic play, input logic stop, input logic tick);
    i_rec_cmd = rec; i_play_cmd = play; i_stop_cmd = stop; i_sample_tick = tick;
    @(posedge clk); #1;
    i_rec_cmd = 1'b0; i_play_cmd = 1'b0; i_stop_cmd = 1'b0; i_sample_tick = 1'b0;
  endtask

  // Tick followed by a gap cycle; optionally queue the strobe it should cause.
  task automatic tick_gap(input bit expect_strobe, input bit we, input int unsigned a);
    if (expect_strobe) sb.push_back('{we: we, addr: ADDR_W'(a)});
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step(0, 0, 0, 0);
    i_reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b0; i_rec_cmd = 1'b0; i_play_cmd = 1'b0; i_stop_cmd = 1'b0; i_sample_tick = 1'b0;
    do_reset();
    check("rst_state", {27'd0, o_mem_we, o_mem_re, o_recording, o_playing, o_done}, 32'd0);
    check("rst_addr", 32'(o_addr), 32'd0);
    check("rst_len", 32'(o_rec_len), 32'd0);

    // play with nothing recorded is ignored
    step(0, 1, 0, 0);
    check("play_empty", {30'd0, o_playing, o_recording}, 32'd0);
    tick_gap(0, 0, 0);

    // record 5 samples then stop
    step(1, 0, 0, 0);
    check("rec_enter", {30'd0, o_recording, o_playing}, 32'd2);
    for (int i = 0; i < 5; i++) tick_gap(1, 1, i);
    step(0, 0, 1, 0);
    exp_done++;
    check("rec5_done", {30'd0, o_done, o_recording}, 32'd2);
    check("rec5_len", 32'(o_rec_len), 32'd5);
    step(0, 0, 0, 0);
    check("done_pulse", 32'(o_done), 32'd0);

    // play back 5 samples with auto exit; sixth tick is inert
    step(0, 1, 0, 0);
    check("play_enter", 32'(o_playing), 32'd1);
    for (int i = 0; i < 5; i++) tick_gap(1, 0, i);
    exp_done++;
    check("play_done", {30'd0, o_done, o_playing}, 32'd2);
    check("play_addr0", 32'(o_addr), 32'd0);
    tick_gap(0, 0, 0);
    check("play_len_kept", 32'(o_rec_len), 32'd5);

    // fill the memory: 10 ticks give DEPTH writes and an auto exit
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick_gap(1, 1, i);
    exp_done++;
    check("full_done", {30'd0, o_done, o_recording}, 32'd2);
    check("full_len", 32'(o_rec_len), 32'(DEPTH));
    check("full_addr0", 32'(o_addr), 32'd0);
    tick_gap(0, 0, 0);
    tick_gap(0, 0, 0);

    // stop together with a tick after 3 writes: no 4th write
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick_gap(1, 1, i);
    step(0, 0, 1, 1);
    exp_done++;
    check("stoptick_len", 32'(o_rec_len), 32'd3);
    check("stoptick_done", 32'(o_done), 32'd1);
    step(0, 0, 0, 0);

    // stop during the 3rd write strobe: that write still counts
    step(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) tick_gap(1, 1, i);
    sb.push_back('{we: 1'b1, addr: ADDR_W'(2)});
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    exp_done++;
    check("stopstrobe_len", 32'(o_rec_len), 32'd3);
    check("stopstrobe_idle", {30'd0, o_done, o_recording}, 32'd2);

    // stop during playback with a read in flight
    step(0, 1, 0, 0);
    sb.push_back('{we: 1'b0, addr: ADDR_W'(0)});
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    exp_done++;
    check("playstop", {29'd0, o_done, o_playing, o_mem_re}, 32'd4);
    check("playstop_len", 32'(o_rec_len), 32'd3);
    step(0, 0, 0, 0);

    // rec and play together: record wins; rec_cmd during play ignored
    step(1, 1, 0, 0);
    check("recplay_pri", {30'd0, o_recording, o_playing}, 32'd2);
    tick_gap(1, 1, 0);
    step(0, 0, 1, 0);
    exp_done++;
    check("recplay_len", 32'(o_rec_len), 32'd1);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    check("rec_in_play", {30'd0, o_recording, o_playing}, 32'd1);
    tick_gap(1, 0, 0);
    exp_done++;
    check("play1_done", {30'd0, o_done, o_playing}, 32'd2);

    // reset mid-record after 4 writes discards the recording
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick_gap(1, 1, i);
    do_reset();
    check("midrst_out", {27'd0, o_mem_we, o_mem_re, o_recording, o_playing, o_done}, 32'd0);
    check("midrst_len", 32'(o_rec_len), 32'd0);
    step(0, 1, 0, 0);
    check("midrst_play", 32'(o_playing), 32'd0);
    tick_gap(0, 0, 0);
    step(0, 0, 0, 0);

    check("done_count", done_cnt, exp_done);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/record_play_ctrl.md
# record_play_ctrl

Sequencing controller for the audio sample memory. It turns single-cycle record, play and stop commands plus the audio sample-rate strobe into memory address, write-enable and read-enable sequences. It tracks the length of the last recording and replays exactly that many samples. It sits between the debounced button logic / sample-rate divider and the sample BRAM, and replaces free-running address counting with a state-controlled address.

## Interface
- ADDR_W, 17, address width of the sample memory
- DEPTH, 131072, number of sample locations; 2 ≤ DEPTH ≤ 2^ADDR_W
- clk  input  1  system clock; single clock domain
- reset  input  1  synchronous, active-high reset
- rec_cmd  input  1  one-cycle pulse: start recording
- play_cmd  input  1  one-cycle pulse: start playback
- stop_cmd  input  1  one-cycle pulse: abort recording/playback
- sample_tick  input  1  one-cycle strobe at audio sample rate
- addr  output  ADDR_W  memory address; valid whenever mem_we/mem_re high
- mem_we  output  1  registered one-cycle write strobe (record)
- mem_re  output  1  registered one-cycle read strobe (playback)
- rec_len  output  ADDR_W+1  samples held by last recording (0..DEPTH)
- recording  output  1  high in RECORD
- playing  output  1  high in PLAY
- done  output  1  one-cycle pulse on every exit from RECORD or PLAY

## Operation
- States: IDLE, RECORD, PLAY. The recording and playing outputs decode the state directly.
- Command priority when several are high in one cycle: stop_cmd > rec_cmd > play_cmd.
- IDLE:
  - rec_cmd → RECORD, addr←0.
  - play_cmd with rec_len≠0 → PLAY, addr←0.
  - play_cmd with rec_len=0 is ignored.
  - stop_cmd is a no-op.
- RECORD: sample_tick (without stop_cmd) → mem_we=1 in the next cycle with addr equal to the current write location. addr increments on the edge that ends the strobe cycle.
- RECORD end:
  - stop_cmd → IDLE. rec_len←number of completed writes. A strobe already high in the stop cycle completes and counts.
  - Strobe at addr=DEPTH−1 (memory full) → IDLE, rec_len←DEPTH, addr←0, done.
- RECORD overwrites from location 0; the previous rec_len is replaced only when RECORD exits.
- PLAY: sample_tick → mem_re=1 in the next cycle with the current addr; addr increments after the strobe.
- PLAY end:
  - The strobe at addr=rec_len−1 → IDLE, addr←0, done.
  - stop_cmd → IDLE immediately; an in-flight strobe still completes. rec_len is unchanged.
- rec_cmd during PLAY and play_cmd during RECORD are ignored.
- sample_tick arriving while a strobe is high is dropped. Ticks are spaced at least 2 clk cycles apart.
- mem_we and mem_re are never high together.

## Timing
- Reset (synchronous): state=IDLE, addr=0, mem_we=0, mem_re=0, rec_len=0, done=0.
- Reset mid-recording discards the partial recording: rec_len=0 and no done pulse.
- Command → state change: 1 cycle. recording/playing go high on the edge after the command.
- sample_tick (cycle N) → strobe high in cycle N+1 → addr+1 visible in N+2.
- done is high in the cycle after the final strobe or after the stop_cmd. recording/playing are already low in that cycle.
- Auto-exit on full: done follows the DEPTH-th write strobe by 1 cycle.
- stop_cmd together with sample_tick: stop wins and no new strobe is issued.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- Reset, then rec_cmd and 5 ticks, then stop_cmd → mem_we at addr 0,1,2,3,4; rec_len=5; one done pulse; state IDLE.
- Following play_cmd plus ticks → mem_re at addr 0..4; auto done after the 5th strobe; 6th tick produces no strobe; addr=0.
- DEPTH=8, record with 10 ticks → 8 writes (addr 0..7); rec_len=8; auto exit with done; ticks 9–10 produce no mem_we.
- stop_cmd in the same cycle as a tick after 3 writes → no 4th write; rec_len=3. stop_cmd during the 3rd strobe cycle → rec_len=3.
- After reset, play_cmd with rec_len=0 → stays IDLE, no mem_re, no done. rec_cmd+play_cmd together → RECORD.
- Reset asserted mid-RECORD after 4 writes → next cycle all outputs 0, rec_len=0; subsequent play_cmd ignored.
